// File: rtl/gemm_tile_scheduler_if.sv
// System-bus port of the gemm accelerator, as seen by the tile scheduler.
interface gemm_tile_scheduler_if;
    logic        system_bus_en;
    logic        system_bus_rdwr;
    logic [31:0] system_bus_addr;
    logic [31:0] system_bus_wr_data;
    logic [31:0] system_bus_rd_data;

    modport master (
        output system_bus_en,
        output system_bus_rdwr,
        output system_bus_addr,
        output system_bus_wr_data,
        input  system_bus_rd_data
    );

    modport slave (
        input  system_bus_en,
        input  system_bus_rdwr,
        input  system_bus_addr,
        input  system_bus_wr_data,
        output system_bus_rd_data
    );
endinterface

// File: rtl/gemm_tile_scheduler.sv
// Walks the n/m/k tile loops of an int8 GEMM job and programs each tile into
// the gemm accelerator over its system bus, throttling on FULL and polling DONE.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | waiting for start; bus idle, addr/data hold last value
// WR_ASTR    | write A stride (K) to BASE+12, once per job
// WR_BSTR    | write B stride (N) to BASE+16, once per job
// WR_A..DIM  | five tile register writes (A, B, C, CTRL, DIM)
// RD_FULL    | issue FULL read at BASE+0
// CHK_FULL   | keep reading; stay while FULL=1, else advance tile counters
// RD_DONE    | issue DONE read at BASE+24
// CHK_DONE   | keep reading; stay while DONE=0
// DONE       | one-cycle done pulse, back to IDLE
module gemm_tile_scheduler #(
    parameter int unsigned BLKN      = 16,
    parameter int unsigned BLKK      = 16,
    parameter int unsigned BLKM      = 16,
    parameter logic [31:0] BASE_ADDR = 32'h9000_0000,
    parameter int unsigned DIM_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIM_W-1:0] dim_m,
    input  logic [DIM_W-1:0] dim_k,
    input  logic [DIM_W-1:0] dim_n,
    input  logic [31:0]      a_addr,
    input  logic [31:0]      b_addr,
    input  logic [31:0]      c_addr,
    output logic             busy,
    output logic             done,
    gemm_tile_scheduler_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_WR_ASTR, S_WR_BSTR, S_WR_A, S_WR_B, S_WR_C, S_WR_CTRL,
        S_WR_DIM, S_RD_FULL, S_CHK_FULL, S_RD_DONE, S_CHK_DONE, S_DONE
    } state_t;

    localparam logic [DIM_W-1:0] BLKN_D = DIM_W'(BLKN);
    localparam logic [DIM_W-1:0] BLKK_D = DIM_W'(BLKK);
    localparam logic [DIM_W-1:0] BLKM_D = DIM_W'(BLKM);

    state_t           state_q, state_d;
    logic [DIM_W-1:0] ki_q, ki_d, mi_q, mi_d, ni_q, ni_d;
    logic [DIM_W-1:0] dim_m_q, dim_k_q, dim_n_q;
    logic [31:0]      a_q, b_q, c_q;
    logic [31:0]      hold_addr_q, hold_data_q;

    logic [DIM_W-1:0] k_rem, m_rem, n_rem;
    logic [DIM_W:0]   k_end, m_end, n_end;
    logic [4:0]       ksize, msize, nsize;
    logic [31:0]      tile_a, tile_b, tile_c, tile_ctrl, tile_dim;
    logic             en_c, rdwr_c;
    logic [31:0]      addr_c, wdata_c;
    logic             accept;
    logic             unused_rd;

    assign accept    = (state_q == S_IDLE) && start;
    assign unused_rd = ^bus.system_bus_rd_data[31:1];

    // Current tile geometry and register values, all derived from the loop counters.
    always_comb begin
        k_rem     = dim_k_q - ki_q;
        m_rem     = dim_m_q - mi_q;
        n_rem     = dim_n_q - ni_q;
        k_end     = {1'b0, ki_q} + {1'b0, BLKK_D};
        m_end     = {1'b0, mi_q} + {1'b0, BLKM_D};
        n_end     = {1'b0, ni_q} + {1'b0, BLKN_D};
        ksize     = (k_rem > BLKK_D) ? BLKK_D[4:0] : k_rem[4:0];
        msize     = (m_rem > BLKM_D) ? BLKM_D[4:0] : m_rem[4:0];
        nsize     = (n_rem > BLKN_D) ? BLKN_D[4:0] : n_rem[4:0];
        tile_a    = a_q + 32'(ki_q) + 32'(mi_q) * 32'(dim_k_q);
        tile_b    = b_q + 32'(ni_q) + (32'(ki_q) + 32'(ksize) - 32'd1) * 32'(dim_n_q);
        tile_c    = c_q + 32'(ni_q) + 32'(mi_q) * 32'(dim_n_q);
        tile_ctrl = {30'b0, ki_q == '0, k_end >= {1'b0, dim_k_q}};
        tile_dim  = {17'b0, nsize, ksize, msize};
    end

    // Bus outputs decoded from state; IDLE/DONE replay the last address and data.
    always_comb begin
        en_c    = 1'b0;
        rdwr_c  = 1'b0;
        addr_c  = hold_addr_q;
        wdata_c = hold_data_q;
        case (state_q)
            S_WR_ASTR:  begin en_c = 1'b1; rdwr_c = 1'b1; addr_c = BASE_ADDR + 32'd12; wdata_c = 32'(dim_k_q); end
            S_WR_BSTR:  begin en_c = 1'b1; rdwr_c = 1'b1; addr_c = BASE_ADDR + 32'd16; wdata_c = 32'(dim_n_q); end
            S_WR_A:     begin en_c = 1'b1; rdwr_c = 1'b1; addr_c = BASE_ADDR;          wdata_c = tile_a;    end
            S_WR_B:     begin en_c = 1'b1; rdwr_c = 1'b1; addr_c = BASE_ADDR + 32'd4;  wdata_c = tile_b;    end
            S_WR_C:     begin en_c = 1'b1; rdwr_c = 1'b1; addr_c = BASE_ADDR + 32'd8;  wdata_c = tile_c;    end
            S_WR_CTRL:  begin en_c = 1'b1; rdwr_c = 1'b1; addr_c = BASE_ADDR + 32'd20; wdata_c = tile_ctrl; end
            S_WR_DIM:   begin en_c = 1'b1; rdwr_c = 1'b1; addr_c = BASE_ADDR + 32'd24; wdata_c = tile_dim;  end
            S_RD_FULL,
            S_CHK_FULL: begin en_c = 1'b1; addr_c = BASE_ADDR; end
            S_RD_DONE,
            S_CHK_DONE: begin en_c = 1'b1; addr_c = BASE_ADDR + 32'd24; end
            default:    ;
        endcase
    end

    assign bus.system_bus_en      = en_c;
    assign bus.system_bus_rdwr    = rdwr_c;
    assign bus.system_bus_addr    = addr_c;
    assign bus.system_bus_wr_data = wdata_c;
    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

    // Next state and tile-loop stepping (k innermost, then m, then n).
    always_comb begin
        state_d = state_q;
        ki_d    = ki_q;
        mi_d    = mi_q;
        ni_d    = ni_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ki_d = '0;
                    mi_d = '0;
                    ni_d = '0;
                    if (dim_m == '0 || dim_k == '0 || dim_n == '0) state_d = S_DONE;
                    else                                            state_d = S_WR_ASTR;
                end
            end
            S_WR_ASTR: state_d = S_WR_BSTR;
            S_WR_BSTR: state_d = S_WR_A;
            S_WR_A:    state_d = S_WR_B;
            S_WR_B:    state_d = S_WR_C;
            S_WR_C:    state_d = S_WR_CTRL;
            S_WR_CTRL: state_d = S_WR_DIM;
            S_WR_DIM:  state_d = S_RD_FULL;
            S_RD_FULL: state_d = S_CHK_FULL;
            S_CHK_FULL: begin
                if (!bus.system_bus_rd_data[0]) begin
                    if (k_end < {1'b0, dim_k_q}) begin
                        ki_d    = ki_q + BLKK_D;
                        state_d = S_WR_A;
                    end else if (m_end < {1'b0, dim_m_q}) begin
                        ki_d    = '0;
                        mi_d    = mi_q + BLKM_D;
                        state_d = S_WR_A;
                    end else if (n_end < {1'b0, dim_n_q}) begin
                        ki_d    = '0;
                        mi_d    = '0;
                        ni_d    = ni_q + BLKN_D;
                        state_d = S_WR_A;
                    end else begin
                        state_d = S_RD_DONE;
                    end
                end
            end
            S_RD_DONE:  state_d = S_CHK_DONE;
            S_CHK_DONE: if (bus.system_bus_rd_data[0]) state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // State, loop counters, latched job parameters and held bus values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ki_q        <= '0;
            mi_q        <= '0;
            ni_q        <= '0;
            dim_m_q     <= '0;
            dim_k_q     <= '0;
            dim_n_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
        end else begin
            state_q     <= state_d;
            ki_q        <= ki_d;
            mi_q        <= mi_d;
            ni_q        <= ni_d;
            hold_addr_q <= addr_c;
            hold_data_q <= wdata_c;
            if (accept) begin
                dim_m_q <= dim_m;
                dim_k_q <= dim_k;
                dim_n_q <= dim_n;
                a_q     <= a_addr;
                b_q     <= b_addr;
                c_q     <= c_addr;
            end
        end
    end
endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Scoreboard bench for gemm_tile_scheduler: a loop-level job model queues the
// expected bus writes and done latency; a negedge monitor checks the DUT.
module tb_gemm_tile_scheduler;
    localparam logic [31:0] BASE = 32'h9000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dim_m = '0, dim_k = '0, dim_n = '0;
    logic [31:0] a_addr = '0, b_addr = '0, c_addr = '0;
    logic        busy, done;

    gemm_tile_scheduler_if bif ();

    gemm_tile_scheduler dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .dim_m  (dim_m),
        .dim_k  (dim_k),
        .dim_n  (dim_n),
        .a_addr (a_addr),
        .b_addr (b_addr),
        .c_addr (c_addr),
        .busy   (busy),
        .done   (done),
        .bus    (bif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_w[$];
    int  exp_lat[$];
    int  passed = 0;
    int  total = 0;
    int  cyc = 0;
    int  start_cyc = 0;
    int  full_cfg = 0, done_cfg = 0;
    int  full_left = 0, done_left = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    // gemm responder: FULL reads return 1 full_cfg times per job, DONE reads
    // return 0 done_cfg times per job; data appears the cycle after the request.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            bif.system_bus_rd_data <= '0;
            full_left = 0;
            done_left = 0;
        end else begin
            if (start && !busy) begin
                full_left = full_cfg;
                done_left = done_cfg;
            end
            if (bif.system_bus_en && !bif.system_bus_rdwr) begin
                if (bif.system_bus_addr == BASE) begin
                    if (full_left > 0) begin
                        bif.system_bus_rd_data <= 32'd1;
                        full_left = full_left - 1;
                    end else bif.system_bus_rd_data <= 32'd0;
                end else if (bif.system_bus_addr == BASE + 32'd24) begin
                    if (done_left > 0) begin
                        bif.system_bus_rd_data <= 32'd0;
                        done_left = done_left - 1;
                    end else bif.system_bus_rd_data <= 32'd1;
                end
            end
        end
    end

    // Monitor: every bus write and every done pulse is matched against the queues.
    always @(negedge clk) begin
        if (bif.system_bus_en && bif.system_bus_rdwr) begin
            if (exp_w.size() == 0) begin
                total++;
                $display("FAIL write_unexpected: got addr %h data %h, want no write",
                         bif.system_bus_addr, bif.system_bus_wr_data);
            end else begin
                wr_t e;
                e = exp_w.pop_front();
                chk("wr_addr", bif.system_bus_addr, e.addr);
                chk("wr_data", bif.system_bus_wr_data, e.data);
            end
        end
        if (done) begin
            if (exp_lat.size() == 0) begin
                total++;
                $display("FAIL done_unexpected: got done at cycle %0d, want none", cyc);
            end else begin
                int e;
                e = exp_lat.pop_front();
                chk("done_latency", 32'(cyc - start_cyc), 32'(e));
                chk("busy_at_done", {31'b0, busy}, 32'd1);
            end
        end
    end

    task automatic push_w(input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_w.push_back(w);
    endtask

    // Job model: plain triple loop over tile origins.
    task automatic model_job(input int M, input int K, input int N,
                             input logic [31:0] aa, input logic [31:0] bb,
                             input logic [31:0] cc, input int fs, input int ds);
        int tiles;
        tiles = 0;
        if (M == 0 || K == 0 || N == 0) begin
            exp_lat.push_back(1);
            return;
        end
        push_w(BASE + 32'd12, 32'(K));
        push_w(BASE + 32'd16, 32'(N));
        for (int n = 0; n < N; n += 16)
            for (int m = 0; m < M; m += 16)
                for (int k = 0; k < K; k += 16) begin
                    int ns, ms, ks;
                    ns = (N - n < 16) ? N - n : 16;
                    ms = (M - m < 16) ? M - m : 16;
                    ks = (K - k < 16) ? K - k : 16;
                    push_w(BASE,          aa + 32'(k) + 32'(m * K));
                    push_w(BASE + 32'd4,  bb + 32'(n) + 32'((k + ks - 1) * N));
                    push_w(BASE + 32'd8,  cc + 32'(n) + 32'(m * N));
                    push_w(BASE + 32'd20, {30'b0, k == 0, k + 16 >= K});
                    push_w(BASE + 32'd24, 32'(ms | (ks << 5) | (ns << 10)));
                    tiles++;
                end
        exp_lat.push_back(12 + 7 * (tiles - 1) + fs + ds);
    endtask

    // early=1: raise start during the DONE cycle; acceptance must be the next (IDLE) cycle.
    task automatic start_job(input int M, input int K, input int N,
                             input logic [31:0] aa, input logic [31:0] bb,
                             input logic [31:0] cc, input int fs, input int ds,
                             input bit early, input bit use_model);
        if (!early) @(negedge clk);
        dim_m = 16'(M); dim_k = 16'(K); dim_n = 16'(N);
        a_addr = aa; b_addr = bb; c_addr = cc;
        full_cfg = fs; done_cfg = ds;
        start = 1'b1;
        if (early) @(negedge clk);
        start_cyc = cyc;
        if (use_model) model_job(M, K, N, aa, bb, cc, fs, ds);
        @(negedge clk);
        start = 1'b0;
        dim_m = 16'($urandom); dim_k = 16'($urandom); dim_n = 16'($urandom);
        a_addr = $urandom; b_addr = $urandom; c_addr = $urandom;
    endtask

    task automatic wait_done(input string nm, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        total++;
        if (seen) passed++;
        else $display("FAIL %s_timeout: got no done within %0d cycles, want done", nm, limit);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_en",    {31'b0, bif.system_bus_en},   32'd0);
        chk("rst_rdwr",  {31'b0, bif.system_bus_rdwr}, 32'd0);
        chk("rst_addr",  bif.system_bus_addr,           32'd0);
        chk("rst_wdata", bif.system_bus_wr_data,        32'd0);
        chk("rst_busy",  {31'b0, busy},                 32'd0);
        chk("rst_done",  {31'b0, done},                 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single 16x16x16 tile: exact trace written out by hand.
        push_w(BASE + 32'd12, 32'd16);
        push_w(BASE + 32'd16, 32'd16);
        push_w(BASE,          32'h1000_0000);
        push_w(BASE + 32'd4,  32'h2000_0000 + 32'd240);
        push_w(BASE + 32'd8,  32'h3000_0000);
        push_w(BASE + 32'd20, 32'd3);
        push_w(BASE + 32'd24, 32'd16912);
        exp_lat.push_back(12);
        start_job(16, 16, 16, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 0, 0, 1'b0, 1'b0);
        wait_done("single_tile", 100);

        // Partial tiles in every dimension, start raised in the DONE cycle.
        start_job(20, 40, 18, 32'h0000_1000, 32'h0000_8000, 32'h0001_0000, 0, 0, 1'b1, 1'b1);
        wait_done("partial", 300);

        // FULL held high after tile 1, plus a slow DONE.
        start_job(32, 16, 16, 32'hAAAA_0000, 32'hBBBB_0000, 32'hCCCC_0000, 5, 2, 1'b0, 1'b1);
        wait_done("full_stall", 300);

        // Zero dimension: no bus traffic, busy for exactly the DONE cycle.
        start_job(16, 16, 0, 32'h1, 32'h2, 32'h3, 0, 0, 1'b0, 1'b1);
        chk("zero_busy",  {31'b0, busy}, 32'd1);
        chk("zero_done",  {31'b0, done}, 32'd1);
        chk("zero_en",    {31'b0, bif.system_bus_en}, 32'd0);
        @(negedge clk);
        chk("zero_busy_after", {31'b0, busy}, 32'd0);
        chk("zero_done_after", {31'b0, done}, 32'd0);

        // start while busy with other dims must be ignored.
        start_job(20, 40, 18, 32'h4000_0000, 32'h5000_0000, 32'hFFFF_FF00, 0, 1, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        dim_m = 16'd5; dim_k = 16'd5; dim_n = 16'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start", 300);

        // Random jobs, alternating DONE-cycle starts.
        for (int i = 0; i < 10; i++) begin
            int M, K, N;
            M = (i == 3) ? 48 : $urandom_range(1, 40);
            K = (i == 5) ? 32 : $urandom_range(1, 40);
            N = $urandom_range(1, 40);
            start_job(M, K, N, $urandom, $urandom, $urandom,
                      $urandom_range(0, 3), $urandom_range(0, 3), i[0], 1'b1);
            wait_done("random", 1000);
        end

        // Reset during WR_C of tile 3, then a clean job from the stride writes.
        begin
            int cnt;
            cnt = 0;
            start_job(40, 40, 40, 32'h1234_0000, 32'h2345_0000, 32'h3456_0000, 0, 0, 1'b0, 1'b1);
            for (int i = 0; i < 200 && cnt < 3; i++) begin
                @(negedge clk);
                if (bif.system_bus_en && bif.system_bus_rdwr && bif.system_bus_addr == BASE + 32'd8)
                    cnt++;
            end
            chk("reach_tile3_wrc", 32'(cnt), 32'd3);
            rst = 1'b0;
            #1;
            chk("midrst_en",    {31'b0, bif.system_bus_en},   32'd0);
            chk("midrst_rdwr",  {31'b0, bif.system_bus_rdwr}, 32'd0);
            chk("midrst_addr",  bif.system_bus_addr,           32'd0);
            chk("midrst_wdata", bif.system_bus_wr_data,        32'd0);
            chk("midrst_busy",  {31'b0, busy},                 32'd0);
            exp_w.delete();
            exp_lat.delete();
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            start_job(20, 40, 18, 32'h0000_1000, 32'h0000_8000, 32'h0001_0000, 1, 1, 1'b0, 1'b1);
            wait_done("after_reset", 300);
        end

        @(negedge clk);
        chk("writes_left", 32'(exp_w.size()),   32'd0);
        chk("done_left",   32'(exp_lat.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
